ring_count_reader: RTL and testbench
====================================

RING_COUNT_READER -- requirements
Module: ring_count_reader

Interface
REQ-001 SHALL have parameter WINDOW, default 1000: measurement gate length in clk cycles (1..65535).
REQ-002 SHALL have parameter SETTLE, default 4: clk cycles to wait after gate close before sampling the count (1..255).
REQ-003 SHALL have parameter CLKS_PER_BIT, default 868: serial bit period in clk cycles (2..65535).
REQ-004 SHALL have port clk, input, 1: single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port start, input, 1: request one measurement; sampled only in IDLE.
REQ-007 SHALL have port count_in, input, 16: count value from the counting circuit (its value_out).
REQ-008 SHALL have port ring_en, output, 1: ring oscillator/count gate enable.
REQ-009 SHALL have port cnt_clr, output, 1: clear strobe to the counting circuit.
REQ-010 SHALL have port tx, output, 1: serial result line, idle high.
REQ-011 SHALL have port busy, output, 1: measurement or transmission in progress.
REQ-012 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-013 SHALL have port sample, output, 16: last captured count.

Function
REQ-014 SHALL implement FSM states IDLE, CLEAR, GATE, SETTLE, CAPTURE, TX, DONE; the only transitions are IDLE->CLEAR->GATE->SETTLE->CAPTURE->TX->DONE->IDLE.
REQ-015 SHALL leave IDLE on the edge where start=1 (cycle 0); start SHALL be ignored in every other state.
REQ-016 SHALL hold cnt_clr=1 for exactly one cycle (cycle 1, CLEAR) and 0 otherwise.
REQ-017 SHALL hold ring_en=1 for exactly WINDOW consecutive cycles (cycles 2..WINDOW+1, GATE) and 0 otherwise.
REQ-018 SHALL wait exactly SETTLE cycles in SETTLE with ring_en=0.
REQ-019 SHALL load sample<=count_in at the end of the single CAPTURE cycle (cycle WINDOW+SETTLE+2); sample SHALL otherwise hold.
REQ-020 SHALL in TX send two back-to-back 8N1 frames: sample[7:0] first, then sample[15:8]; each frame = start bit 0, 8 data bits LSB first, stop bit 1; each bit exactly CLKS_PER_BIT cycles; 20*CLKS_PER_BIT cycles total.
REQ-021 SHALL begin the first start bit at cycle WINDOW+SETTLE+3 and drive tx=1 in all non-TX states.
REQ-022 SHALL transmit the captured value; changes on count_in after CAPTURE SHALL NOT affect tx or sample.
REQ-023 SHALL pulse done=1 for one cycle (DONE, cycle WINDOW+SETTLE+3+20*CLKS_PER_BIT), then return to IDLE.
REQ-024 SHALL drive busy=1 in all states except IDLE and 0 in IDLE.
REQ-025 SHALL transmit boundary values unmodified: 0x0000 as bytes 00 00, 0xFFFF as FF FF; no saturation or arithmetic on count_in.
REQ-026 SHALL accept start held high continuously as back-to-back measurements: one new CLEAR on the edge after each DONE, with one cnt_clr per measurement.
REQ-027 SHALL use internal bit/cycle counters wide enough for max parameter values without wrap-around inside a state.

Reset
REQ-028 SHALL, while rst=1 (asynchronous, immediate), force state=IDLE, ring_en=0, cnt_clr=0, tx=1, busy=0, done=0, sample=16'h0000 and clear all internal counters.
REQ-029 SHALL on rst asserted mid-operation (any state) abandon the measurement with no partial frame completion; the first start after rst deasserts SHALL run a full measurement.

Verification (WINDOW=10, SETTLE=4, CLKS_PER_BIT=4)
REQ-030 SHALL cover: rst=1 with clk running -> tx=1, ring_en=0, cnt_clr=0, busy=0, done=0, sample=0x0000.
REQ-031 SHALL cover: count_in=0x1234, one-cycle start -> cnt_clr at cycle 1, ring_en high cycles 2..11, sample=0x1234 after cycle 16, tx frames 0x34 then 0x12 starting cycle 17, done at cycle 97, busy low from cycle 98.
REQ-032 SHALL cover: start held high for 3 measurements -> exactly 3 cnt_clr pulses, 3 done pulses spaced 98 cycles apart.
REQ-033 SHALL cover: count_in=0x0000 then 0xFFFF -> tx bytes 00 00 then FF FF with correct start/stop bits.
REQ-034 SHALL cover: count_in changed to 0xABCD during TX after capturing 0x1234 -> tx still 0x34, 0x12; sample stays 0x1234.
REQ-035 SHALL cover: rst pulsed at cycle 6 (GATE) -> ring_en=0 and tx=1 immediately, no done; next start yields full 97-cycle sequence.

Source files
------------

// File: rtl/ring_count_reader.sv
// Gated ring-oscillator count reader: clears the counter, opens a fixed gate,
// lets the count settle, captures it and sends it LSB byte first over 8N1 serial.
module ring_count_reader #(
  parameter int unsigned WINDOW       = 1000,
  parameter int unsigned SETTLE       = 4,
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] count_in,
  output logic        ring_en,
  output logic        cnt_clr,
  output logic        tx,
  output logic        busy,
  output logic        done,
  output logic [15:0] sample
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_GATE,
    ST_SETTLE,
    ST_CAPTURE,
    ST_TX,
    ST_DONE
  } state_t;

  localparam logic [15:0] GATE_LAST   = 16'(WINDOW - 1);
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE - 1);
  localparam logic [15:0] BIT_LAST    = 16'(CLKS_PER_BIT - 1);
  localparam logic [4:0]  LAST_BIT    = 5'd19;

  state_t      state;
  logic [15:0] cnt;
  logic [4:0]  bit_idx;

  // Bit idx 0..19 spans two 10-bit frames: start, 8 data LSB first, stop.
  function automatic logic frame_bit(input logic [15:0] data, input logic [4:0] idx);
    logic [4:0] pos;
    logic [7:0] byte_v;
    pos    = (idx >= 5'd10) ? idx - 5'd10 : idx;
    byte_v = (idx >= 5'd10) ? data[15:8] : data[7:0];
    if (pos == 5'd0)
      return 1'b0;
    else if (pos == 5'd9)
      return 1'b1;
    else
      return byte_v[3'(pos - 5'd1)];
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      ring_en <= 1'b0;
      cnt_clr <= 1'b0;
      tx      <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      sample  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_CLEAR;
            cnt_clr <= 1'b1;
            busy    <= 1'b1;
          end
        end
        ST_CLEAR: begin
          state   <= ST_GATE;
          cnt_clr <= 1'b0;
          ring_en <= 1'b1;
          cnt     <= '0;
        end
        ST_GATE: begin
          if (cnt == GATE_LAST) begin
            state   <= ST_SETTLE;
            ring_en <= 1'b0;
            cnt     <= '0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ST_SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            state <= ST_CAPTURE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ST_CAPTURE: begin
          state   <= ST_TX;
          sample  <= count_in;
          tx      <= 1'b0;
          bit_idx <= '0;
          cnt     <= '0;
        end
        ST_TX: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (bit_idx == LAST_BIT) begin
              state <= ST_DONE;
              tx    <= 1'b1;
              done  <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 5'd1;
              tx      <= frame_bit(sample, bit_idx + 5'd1);
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ring_count_reader.sv
// Bench for ring_count_reader: per-cycle comparison against a timeline model
// plus directed scenarios with hand-computed cycle numbers and serial bytes.
module tb_ring_count_reader;

  localparam int unsigned W = 10;
  localparam int unsigned S = 4;
  localparam int unsigned C = 4;
  localparam int unsigned TX0 = W + S + 3;        // first start bit cycle
  localparam int unsigned D   = TX0 + 20 * C;     // done cycle

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] count_in = '0;
  logic        ring_en, cnt_clr, tx, busy, done;
  logic [15:0] sample;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  ring_count_reader #(.WINDOW(W), .SETTLE(S), .CLKS_PER_BIT(C)) dut (
    .clk(clk), .rst(rst), .start(start), .count_in(count_in),
    .ring_en(ring_en), .cnt_clr(cnt_clr), .tx(tx), .busy(busy),
    .done(done), .sample(sample)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Timeline model: rel is the cycle number within a measurement (1 = clear).
  bit          m_active = 1'b0;
  int unsigned m_rel = 0;
  logic [15:0] m_sample = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active <= 1'b0;
      m_rel    <= 0;
      m_sample <= '0;
    end else if (m_active) begin
      if (m_rel == W + S + 2) m_sample <= count_in;
      if (m_rel == D) begin
        m_active <= 1'b0;
        m_rel    <= 0;
      end else begin
        m_rel <= m_rel + 1;
      end
    end else if (start) begin
      m_active <= 1'b1;
      m_rel    <= 1;
    end
  end

  function automatic logic exp_tx(input bit act, input int unsigned rel, input logic [15:0] val);
    int unsigned b, p;
    logic [7:0] by;
    if (!act || rel < TX0 || rel >= D) return 1'b1;
    b  = (rel - TX0) / C;
    p  = b % 10;
    by = (b >= 10) ? val[15:8] : val[7:0];
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    return by[p - 1];
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy",    {31'b0, busy},    {31'b0, m_active});
      check("cnt_clr", {31'b0, cnt_clr}, {31'b0, m_active && m_rel == 1});
      check("ring_en", {31'b0, ring_en}, {31'b0, m_active && m_rel >= 2 && m_rel <= W + 1});
      check("done",    {31'b0, done},    {31'b0, m_active && m_rel == D});
      check("tx",      {31'b0, tx},      {31'b0, exp_tx(m_active, m_rel, m_sample)});
      check("sample",  {16'b0, sample},  {16'b0, m_sample});
    end
  end

  task automatic measure(input logic [15:0] cin, input logic [15:0] cin_late,
                         input logic [7:0] exp_lo, input logic [7:0] exp_hi);
    int unsigned first_clr, n_clr, first_ring, last_ring, first_txlo, done_at, n_done;
    logic [19:0] bits;
    logic busy_after;
    first_clr = 0; n_clr = 0; first_ring = 0; last_ring = 0;
    first_txlo = 0; done_at = 0; n_done = 0; bits = '0; busy_after = 1'b1;
    @(negedge clk);
    count_in = cin;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int unsigned k = 1; k <= 98; k++) begin
      if (cnt_clr) begin
        n_clr++;
        if (first_clr == 0) first_clr = k;
      end
      if (ring_en) begin
        if (first_ring == 0) first_ring = k;
        last_ring = k;
      end
      if (!tx && first_txlo == 0) first_txlo = k;
      if (k >= 17 && k < 97 && ((k - 17) % 4) == 1) bits[(k - 17) / 4] = tx;
      if (done) begin
        n_done++;
        done_at = k;
      end
      if (k == 98) busy_after = busy;
      if (k == 20) count_in = cin_late;
      if (k < 98) @(negedge clk);
    end
    check("clr_cycle",   first_clr, 1);
    check("clr_count",   n_clr, 1);
    check("ring_first",  first_ring, 2);
    check("ring_last",   last_ring, 11);
    check("tx_start",    first_txlo, 17);
    check("done_cycle",  done_at, 97);
    check("done_count",  n_done, 1);
    check("busy_98",     {31'b0, busy_after}, 0);
    check("start_bit0",  {31'b0, bits[0]}, 0);
    check("stop_bit0",   {31'b0, bits[9]}, 1);
    check("start_bit1",  {31'b0, bits[10]}, 0);
    check("stop_bit1",   {31'b0, bits[19]}, 1);
    check("byte_lo",     {24'b0, bits[8:1]}, {24'b0, exp_lo});
    check("byte_hi",     {24'b0, bits[18:11]}, {24'b0, exp_hi});
    check("sample_held", {16'b0, sample}, {16'b0, cin});
  endtask

  initial begin
    int unsigned n_clr, n_done;
    int unsigned done_k [3];

    // Reset with clock running
    repeat (3) @(negedge clk);
    check("rst_tx",      {31'b0, tx}, 1);
    check("rst_ring_en", {31'b0, ring_en}, 0);
    check("rst_cnt_clr", {31'b0, cnt_clr}, 0);
    check("rst_busy",    {31'b0, busy}, 0);
    check("rst_done",    {31'b0, done}, 0);
    check("rst_sample",  {16'b0, sample}, 0);
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);

    measure(16'h1234, 16'hABCD, 8'h34, 8'h12);
    measure(16'h0000, 16'h0000, 8'h00, 8'h00);
    measure(16'hFFFF, 16'hFFFF, 8'hFF, 8'hFF);

    // start held high: three back-to-back measurements
    n_clr = 0; n_done = 0;
    done_k[0] = 0; done_k[1] = 0; done_k[2] = 0;
    @(negedge clk);
    count_in = 16'h0F0F;
    start = 1'b1;
    for (int unsigned k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (k == 250) start = 1'b0;
      if (cnt_clr) n_clr++;
      if (done) begin
        if (n_done < 3) done_k[n_done] = k;
        n_done++;
      end
    end
    check("b2b_clr_count",  n_clr, 3);
    check("b2b_done_count", n_done, 3);
    check("b2b_done_first", done_k[0], 97);
    check("b2b_spacing_1",  done_k[1] - done_k[0], 98);
    check("b2b_spacing_2",  done_k[2] - done_k[1], 98);

    // Reset in the middle of the gate
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("gate_before_rst", {31'b0, ring_en}, 1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_ring_en", {31'b0, ring_en}, 0);
    check("rst_mid_tx",      {31'b0, tx}, 1);
    check("rst_mid_busy",    {31'b0, busy}, 0);
    @(negedge clk);
    rst = 1'b0;
    n_done = 0;
    for (int unsigned k = 0; k < 110; k++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("rst_no_done", n_done, 0);
    measure(16'h5A3C, 16'h5A3C, 8'h3C, 8'h5A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
